// File: rtl/mc_controller.sv
// Multicycle main control FSM for the 32-bit MIPS core.
// Sequences ALU, register file, IR, PC and the unified memory port.
// Optional feature macro: MC_CONTROLLER_BNE_EN (adds BNEEX state and bne output).
module mc_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               memready,
    output logic               memwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         pcsrc,
    output logic               pcwrite,
    output logic               branch,
    output logic               illegal,
`ifdef MC_CONTROLLER_BNE_EN
    output logic               bne,
`endif
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    // Moore control word; registered alongside the state it belongs to
    typedef struct packed {
        logic       memwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite_j;
        logic       branch;
`ifdef MC_CONTROLLER_BNE_EN
        logic       bne;
`endif
    } ctrl_t;

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;

    // Control word for a given state; anything not listed stays 0
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:   c.alusrcb = 2'b01;
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BEQEX:   begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  c.regwrite = 1'b1;
            JEX:     begin c.pcsrc = 2'b10; c.pcwrite_j = 1'b1; end
`ifdef MC_CONTROLLER_BNE_EN
            BNEEX:   begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.bne     = 1'b1;
            end
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic and the illegal-opcode pulse in DECODE
    always_comb begin
        state_d = FETCH;
        illegal = 1'b0;
        case (state_q)
            FETCH:   state_d = memready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_CONTROLLER_BNE_EN
                    OP_BNE:       state_d = BNEEX;
`endif
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = memready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = memready ? FETCH : MEMWR;
            RTYPEEX: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BEQEX:   state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
            JEX:     state_d = FETCH;
`ifdef MC_CONTROLLER_BNE_EN
            BNEEX:   state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    // State register with its registered control word; synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    // FETCH strobes wait on the memory handshake, so they cannot be registered
    assign irwrite  = (state_q == FETCH) && memready;
    assign pcwrite  = irwrite || ctrl_q.pcwrite_j;

    assign memwrite = ctrl_q.memwrite;
    assign iord     = ctrl_q.iord;
    assign regdst   = ctrl_q.regdst;
    assign memtoreg = ctrl_q.memtoreg;
    assign regwrite = ctrl_q.regwrite;
    assign alusrca  = ctrl_q.alusrca;
    assign alusrcb  = ctrl_q.alusrcb;
    assign aluop    = ctrl_q.aluop;
    assign pcsrc    = ctrl_q.pcsrc;
    assign branch   = ctrl_q.branch;
`ifdef MC_CONTROLLER_BNE_EN
    assign bne      = ctrl_q.bne;
`endif
    assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: expected control words are queued per cycle
// and popped when the DUT outputs for that cycle are sampled.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       memready;
    logic       memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcwrite, branch, illegal;
    logic       bne_obs;
    logic [3:0] state;

    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] AI = 6'b001000;
    localparam logic [5:0] JJ = 6'b000010;
    localparam logic [5:0] BN = 6'b000101;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       illegal;
        logic       bne;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    mc_controller #(.STATE_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .memready (memready),
        .memwrite (memwrite),
        .iord     (iord),
        .irwrite  (irwrite),
        .regdst   (regdst),
        .memtoreg (memtoreg),
        .regwrite (regwrite),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluop    (aluop),
        .pcsrc    (pcsrc),
        .pcwrite  (pcwrite),
        .branch   (branch),
        .illegal  (illegal),
`ifdef MC_CONTROLLER_BNE_EN
        .bne      (bne_obs),
`endif
        .state    (state)
    );

`ifndef MC_CONTROLLER_BNE_EN
    assign bne_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    // Expected outputs for a state, written from the control table
    function automatic exp_t model(input int st, input logic [5:0] o, input logic mr);
        exp_t e;
        logic legal;
        e = '0;
        e.st = 4'(st);
`ifdef MC_CONTROLLER_BNE_EN
        legal = (o inside {LW, SW, RT, BQ, AI, JJ, BN});
`else
        legal = (o inside {LW, SW, RT, BQ, AI, JJ});
`endif
        case (st)
            0:  begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
            1:  begin e.alusrcb = 2'b11; e.illegal = ~legal; end
            2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            3:  e.iord = 1'b1;
            4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            6:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            8:  begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.branch = 1'b1; end
            9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            10: e.regwrite = 1'b1;
            11: begin e.pcsrc = 2'b10; e.pcwrite = 1'b1; end
            12: begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.bne = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // One cycle: drive inputs at negedge, queue expectation, sample, compare, advance
    task automatic cyc(input string tag, input int st, input logic [5:0] o,
                       input logic mr, input logic rst = 1'b0);
        exp_t exp_v;
        exp_t obs;
        op       = o;
        memready = mr;
        reset    = rst;
        sb.push_back(model(st, o, mr));
        #1;
        exp_v = sb.pop_front();
        obs.st       = state;
        obs.memwrite = memwrite;
        obs.iord     = iord;
        obs.irwrite  = irwrite;
        obs.regdst   = regdst;
        obs.memtoreg = memtoreg;
        obs.regwrite = regwrite;
        obs.alusrca  = alusrca;
        obs.alusrcb  = alusrcb;
        obs.aluop    = aluop;
        obs.pcsrc    = pcsrc;
        obs.pcwrite  = pcwrite;
        obs.branch   = branch;
        obs.illegal  = illegal;
        obs.bne      = bne_obs;
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        memready = 1'b1;
        op       = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state, then a fetch stall
        cyc("reset_fetch", 0, LW, 1'b0);
        // lw, memready always high: 0,1,2,3,4,0
        cyc("lw_fetch",  0, LW, 1'b1);
        cyc("lw_decode", 1, LW, 1'b1);
        cyc("lw_memadr", 2, LW, 1'b1);
        cyc("lw_memrd",  3, LW, 1'b1);
        cyc("lw_memwb",  4, LW, 1'b1);
        // sw with three wait cycles in MEMWR
        cyc("sw_fetch",  0, SW, 1'b1);
        cyc("sw_decode", 1, SW, 1'b1);
        cyc("sw_memadr", 2, SW, 1'b1);
        cyc("sw_wait0",  5, SW, 1'b0);
        cyc("sw_wait1",  5, SW, 1'b0);
        cyc("sw_wait2",  5, SW, 1'b0);
        cyc("sw_memwr",  5, SW, 1'b1);
        // R-type
        cyc("rt_fetch",  0, RT, 1'b1);
        cyc("rt_decode", 1, RT, 1'b1);
        cyc("rt_ex",     6, RT, 1'b1);
        cyc("rt_wb",     7, RT, 1'b1);
        // beq
        cyc("beq_fetch",  0, BQ, 1'b1);
        cyc("beq_decode", 1, BQ, 1'b1);
        cyc("beq_ex",     8, BQ, 1'b1);
        // addi
        cyc("addi_fetch",  0, AI, 1'b1);
        cyc("addi_decode", 1, AI, 1'b1);
        cyc("addi_ex",     9, AI, 1'b1);
        cyc("addi_wb",    10, AI, 1'b1);
        // j
        cyc("j_fetch",  0, JJ, 1'b1);
        cyc("j_decode", 1, JJ, 1'b1);
        cyc("j_ex",    11, JJ, 1'b1);
        // unsupported opcode
        cyc("bad_fetch",  0, BAD, 1'b1);
        cyc("bad_decode", 1, BAD, 1'b1);
        // bne: its own state when enabled, illegal otherwise
        cyc("bne_fetch",  0, BN, 1'b1);
        cyc("bne_decode", 1, BN, 1'b1);
`ifdef MC_CONTROLLER_BNE_EN
        cyc("bne_ex",    12, BN, 1'b1);
`endif
        // reset while MEMRD is waiting on memory
        cyc("lwr_fetch",  0, LW, 1'b1);
        cyc("lwr_decode", 1, LW, 1'b1);
        cyc("lwr_memadr", 2, LW, 1'b1);
        cyc("lwr_wait",   3, LW, 1'b0);
        cyc("lwr_rst",    3, LW, 1'b0, 1'b1);
        cyc("lwr_after",  0, LW, 1'b1);
        cyc("lwr_decode2", 1, LW, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
